// File: rtl/key3_coeff_loader.sv
// key3_coeff_loader: shadow coefficient bank plus a streaming FSM that feeds
// the key3 pulse FIR filter one coefficient per clock on filter_coeff/coeff_load.
// The bank is writable only while no load is running, so a load always streams
// a consistent coefficient set without needing a snapshot copy.
module key3_coeff_loader #(
  parameter int NUM_TAPS = 8,
  parameter int COEFF_W  = 16,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                               clk_20m,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic        [IDX_W-1:0]            cfg_addr,
  input  logic signed [COEFF_W-1:0]          cfg_data,
  input  logic                               start,
  input  logic                               abort,
  output logic signed [COEFF_W-1:0]          filter_coeff,
  output logic                               coeff_load,
  output logic        [IDX_W-1:0]            tap_idx,
  output logic                               busy,
  output logic                               done,
  output logic                               aborted,
  output logic                               cfg_err,
  output logic signed [COEFF_W+IDX_W-1:0]    coeff_sum
);

  localparam int SUM_W = COEFF_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t                     state;
  logic signed [COEFF_W-1:0]  bank [NUM_TAPS];
  logic signed [SUM_W-1:0]    run_sum;

  logic                       bank_wr;
  logic signed [COEFF_W-1:0]  first_coeff;
  logic        [IDX_W-1:0]    next_idx;
  logic signed [COEFF_W-1:0]  next_coeff;

  // Sign-extend a coefficient to the accumulator width.
  function automatic logic signed [SUM_W-1:0] sext(input logic signed [COEFF_W-1:0] v);
    return {{IDX_W{v[COEFF_W-1]}}, v};
  endfunction

  // A write is accepted only outside a load. Tap 0 is forwarded from the write
  // port so a write issued together with start is the value that gets streamed.
  always_comb begin
    bank_wr     = cfg_we && !busy;
    first_coeff = (bank_wr && (cfg_addr == '0)) ? cfg_data : bank[0];
    next_idx    = tap_idx + IDX_W'(1);
    next_coeff  = bank[next_idx];
  end

  // Shadow bank: every entry resets to +1, host writes land while idle.
  always_ff @(posedge clk_20m) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        bank[i] <= COEFF_W'(1);
      end
    end else if (bank_wr) begin
      bank[cfg_addr] <= cfg_data;
    end
  end

  // Load FSM: all outputs registered; the output registers hold the tap being shown.
  always_ff @(posedge clk_20m) begin
    if (!rst_n) begin
      state        <= IDLE;
      filter_coeff <= '0;
      coeff_load   <= 1'b0;
      tap_idx      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      cfg_err      <= 1'b0;
      coeff_sum    <= '0;
      run_sum      <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (cfg_we && busy) begin
        cfg_err <= 1'b1;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= LOAD;
            cfg_err      <= 1'b0;
            busy         <= 1'b1;
            coeff_load   <= 1'b1;
            tap_idx      <= '0;
            filter_coeff <= first_coeff;
            run_sum      <= sext(first_coeff);
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (abort) begin
            state        <= IDLE;
            busy         <= 1'b0;
            coeff_load   <= 1'b0;
            tap_idx      <= '0;
            filter_coeff <= '0;
            aborted      <= 1'b1;
          end else if (tap_idx == LAST_IDX) begin
            state        <= DONE;
            busy         <= 1'b0;
            coeff_load   <= 1'b0;
            tap_idx      <= '0;
            filter_coeff <= '0;
            done         <= 1'b1;
            coeff_sum    <= run_sum;
          end else begin
            tap_idx      <= next_idx;
            filter_coeff <= next_coeff;
            run_sum      <= run_sum + sext(next_coeff);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key3_coeff_loader.sv
// Directed testbench for key3_coeff_loader with hand-computed expectations.
module tb_key3_coeff_loader;

  localparam int NUM_TAPS = 8;
  localparam int COEFF_W  = 16;
  localparam int IDX_W    = 3;

  logic                            clk_20m;
  logic                            rst_n;
  logic                            cfg_we;
  logic        [IDX_W-1:0]         cfg_addr;
  logic signed [COEFF_W-1:0]       cfg_data;
  logic                            start;
  logic                            abort;
  logic signed [COEFF_W-1:0]       filter_coeff;
  logic                            coeff_load;
  logic        [IDX_W-1:0]         tap_idx;
  logic                            busy;
  logic                            done;
  logic                            aborted;
  logic                            cfg_err;
  logic signed [COEFF_W+IDX_W-1:0] coeff_sum;

  logic signed [COEFF_W-1:0] exp_bank [NUM_TAPS];
  int checkCount;
  int errorCount;

  key3_coeff_loader #(
    .NUM_TAPS(NUM_TAPS),
    .COEFF_W (COEFF_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk_20m     (clk_20m),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .abort       (abort),
    .filter_coeff(filter_coeff),
    .coeff_load  (coeff_load),
    .tap_idx     (tap_idx),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cfg_err     (cfg_err),
    .coeff_sum   (coeff_sum)
  );

  // 20 MHz clock
  initial clk_20m = 1'b0;
  always #25 clk_20m = ~clk_20m;

  // Compare one observed value against its expectation
  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive inputs, then advance to the next falling edge (one rising edge passes)
  task automatic applyStimulus(input logic s, input logic a, input logic we,
                               input logic [IDX_W-1:0] addr, input logic signed [COEFF_W-1:0] data);
    start    = s;
    abort    = a;
    cfg_we   = we;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk_20m);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic writeTap(input logic [IDX_W-1:0] addr, input logic signed [COEFF_W-1:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, addr, data);
    exp_bank[addr] = data;
  endtask

  // Called at the first LOAD cycle; checks the whole stream, done pulse and sum
  task automatic checkStream(input longint expSum);
    for (int k = 0; k < NUM_TAPS; k++) begin
      checkOutput("coeff_load", coeff_load, 1);
      checkOutput("busy", busy, 1);
      checkOutput("tap_idx", tap_idx, k);
      checkOutput("filter_coeff", filter_coeff, exp_bank[k]);
      checkOutput("done_early", done, 0);
      checkOutput("cfg_err_clear", cfg_err, 0);
      idleCycle();
    end
    checkOutput("done", done, 1);
    checkOutput("coeff_sum", coeff_sum, expSum);
    checkOutput("load_off", coeff_load, 0);
    checkOutput("busy_off", busy, 0);
    checkOutput("coeff_zero", filter_coeff, 0);
    checkOutput("idx_zero", tap_idx, 0);
    idleCycle();
    checkOutput("done_pulse", done, 0);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_coeff", filter_coeff, 0);
    checkOutput("rst_load", coeff_load, 0);
    checkOutput("rst_idx", tap_idx, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_aborted", aborted, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    checkOutput("rst_sum", coeff_sum, 0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    for (int i = 0; i < NUM_TAPS; i++) exp_bank[i] = 16'sd1;
    rst_n = 1'b0;
    idleCycle();
    idleCycle();
    checkResetOutputs();
    rst_n = 1'b1;
    idleCycle();

    $display("[TB] default load after reset");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkStream(8);

    $display("[TB] alternating taps, then all most-negative");
    writeTap(0, 16'sd1);  writeTap(1, -16'sd2);
    writeTap(2, 16'sd3);  writeTap(3, -16'sd4);
    writeTap(4, 16'sd5);  writeTap(5, -16'sd6);
    writeTap(6, 16'sd7);  writeTap(7, -16'sd8);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkStream(-4);
    for (int i = 0; i < NUM_TAPS; i++) writeTap(IDX_W'(i), 16'sh8000);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkStream(-262144);

    $display("[TB] write during load is blocked");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3, 16'sd100);
    checkOutput("cfg_err_set", cfg_err, 1);
    idleCycle();
    checkOutput("tap3_idx", tap_idx, 3);
    checkOutput("tap3_old", filter_coeff, -32768);
    for (int j = 0; j < 5; j++) idleCycle();
    checkOutput("blocked_done", done, 1);
    checkOutput("blocked_sum", coeff_sum, -262144);
    idleCycle();
    checkOutput("cfg_err_sticky", cfg_err, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkStream(-262144);

    $display("[TB] start+abort+write together in idle");
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 16'sd77);
    exp_bank[0] = 16'sd77;
    checkStream(77 - 7 * 32768);

    $display("[TB] abort in fourth load cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int j = 1; j <= 3; j++) begin
      checkOutput("abort_load", coeff_load, 1);
      idleCycle();
    end
    checkOutput("abort_load4", coeff_load, 1);
    checkOutput("abort_idx4", tap_idx, 3);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
    checkOutput("abort_off", coeff_load, 0);
    checkOutput("aborted", aborted, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_sum_held", coeff_sum, 77 - 7 * 32768);
    idleCycle();
    checkOutput("aborted_pulse", aborted, 0);
    checkOutput("abort_no_done2", done, 0);

    $display("[TB] start held high, back-to-back loads");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        checkOutput("b2b_load", coeff_load, 1);
        checkOutput("b2b_idx", tap_idx, k);
        checkOutput("b2b_done_low", done, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
      end
      checkOutput("b2b_done", done, 1);
      checkOutput("b2b_sum", coeff_sum, 77 - 7 * 32768);
      applyStimulus((r == 0), 1'b0, 1'b0, '0, '0);
    end
    checkOutput("b2b_stop_load", coeff_load, 0);
    checkOutput("b2b_stop_done", done, 0);

    $display("[TB] reset in fifth load cycle");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    for (int j = 1; j <= 4; j++) idleCycle();
    checkOutput("pre_rst_idx", tap_idx, 4);
    rst_n = 1'b0;
    idleCycle();
    checkResetOutputs();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_TAPS; i++) exp_bank[i] = 16'sd1;
    idleCycle();
    checkOutput("rst_no_done", done, 0);
    idleCycle();
    checkOutput("rst_no_done2", done, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
    checkStream(8);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/key3_coeff_loader.md
# key3_coeff_loader

Coefficient transmitter for the key3 pulse FIR filter. A host writes NUM_TAPS signed coefficients into a local shadow bank. On a start request the block streams them to the filter's serial coefficient port, one per clock on consecutive cycles, with a load strobe. It is the writer side of the filter_coeff/coeff_load interface and sits between the host/config logic and the filter in the 20 MHz domain.

## Interface
- NUM_TAPS, 8, number of coefficients per load; power of two, 2..16
- COEFF_W, 16, coefficient width (two's complement)
- IDX_W, $clog2(NUM_TAPS), tap index width
- clk_20m  input  1  system clock, 20 MHz
- rst_n  input  1  reset; synchronous, active-low
- cfg_we  input  1  shadow-bank write enable
- cfg_addr  input  IDX_W  shadow-bank tap address
- cfg_data  input  COEFF_W  signed coefficient to write
- start  input  1  request a full coefficient load (level sampled each cycle)
- abort  input  1  cancel an in-progress load
- filter_coeff  output  COEFF_W  signed coefficient to filter
- coeff_load  output  1  filter_coeff valid this cycle
- tap_idx  output  IDX_W  index of the tap currently on filter_coeff
- busy  output  1  load in progress
- done  output  1  one-cycle pulse, load completed
- aborted  output  1  one-cycle pulse, load cancelled
- cfg_err  output  1  sticky: write attempted while busy; cleared by next accepted start
- coeff_sum  output  COEFF_W+IDX_W  signed sum of coefficients sent in last completed load

## Operation
- Shadow bank: NUM_TAPS × COEFF_W registers. Reset value of every entry is +1.
- Write rule: cfg_we while busy=0 writes bank[cfg_addr]. cfg_we while busy=1 is ignored and sets cfg_err.
- FSM has three states.
  - IDLE: start=1 moves to LOAD, clears cfg_err, zeroes idx and the running sum, and snapshots nothing. The bank is stable because writes are blocked in LOAD.
  - LOAD: drives coeff_load=1, filter_coeff=bank[idx], tap_idx=idx. Adds the signed, sign-extended bank[idx] to the running sum. idx increments.
    - After idx=NUM_TAPS-1 has been sent, go to DONE.
    - abort=1 in LOAD takes priority: go to IDLE and pulse aborted. coeff_sum is unchanged.
  - DONE: one cycle. done=1, coeff_sum takes the running sum, return to IDLE. start=1 in DONE is accepted and goes directly to LOAD (back-to-back loads).
- start in LOAD is ignored, with no queuing. abort outside LOAD is ignored.
- Simultaneous start and abort in IDLE: start wins and abort is ignored.
- Simultaneous cfg_we and start in IDLE: the write lands first and the load streams the new value.
- Arithmetic: sum width COEFF_W+IDX_W cannot overflow. Sign extension is required (e.g. eight taps of -32768 give -262144).

## Timing
- Reset values (sync, while rst_n=0):
  - state IDLE
  - filter_coeff=0, coeff_load=0, tap_idx=0
  - busy=0, done=0, aborted=0, cfg_err=0, coeff_sum=0
  - bank all +1
- All outputs are registered.
- start sampled high at edge t gives:
  - coeff_load=1 and busy=1 during cycles t+1 … t+NUM_TAPS
  - filter_coeff=bank[k] and tap_idx=k in cycle t+1+k
  - done=1 in cycle t+NUM_TAPS+1, with coeff_sum valid from the same cycle
- Start-to-done latency is NUM_TAPS+1 cycles. Back-to-back period is NUM_TAPS+1 cycles.
- When not in LOAD: filter_coeff=0 and tap_idx=0 (no stale data on the bus).
- abort sampled high at edge in LOAD cycle j: coeff_load=0 from the next cycle, aborted=1 for exactly that cycle, busy=0.
- rst_n low mid-load: outputs return to reset values on the next edge. A partial load is never completed and done does not pulse.

## Test plan
- Default load after reset, start pulse → 8 cycles of coeff_load=1 with filter_coeff=1 and tap_idx 0..7. done one cycle later, coeff_sum=8.
- Write taps {1,-2,3,-4,5,-6,7,-8}, start → stream in that order, coeff_sum=-4. Then all taps 16'h8000 → coeff_sum=-262144.
- cfg_we to addr 3 during LOAD cycle 2 → streamed tap 3 keeps the old value, cfg_err=1. The next start clears cfg_err.
- abort in LOAD cycle 4 → exactly 4 coeff_load cycles, aborted pulse, no done, coeff_sum holds its previous value.
- start held high continuously → loads repeat every 9 cycles with one done per load. start asserted during LOAD has no extra effect.
- rst_n low in LOAD cycle 5 → all outputs 0 next cycle, bank back to all +1. A following start streams +1s.
